// File: rtl/floo_axis_noc_bridge_multichannel.sv
// floo_axis_noc_bridge_multichannel: round-robin mux of NoC flit channels onto one AXIS link and per-channel FIFO demux back.
// Optional saturating discard counter enabled by defining FLOO_AXIS_BRIDGE_DROP_CNT_EN.
module floo_axis_noc_bridge_multichannel #(
  parameter int NumChannels = 2,
  parameter int FlitDataWidth = 64,
  parameter int RxFifoDepth = 2,
  localparam int ChanIdxWidth = $clog2(NumChannels) > 1 ? $clog2(NumChannels) : 1,
  localparam int AxisDataWidth = ChanIdxWidth + FlitDataWidth
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic [NumChannels-1:0]               flit_in_valid_i,
  output logic [NumChannels-1:0]               flit_in_ready_o,
  input  logic [NumChannels*FlitDataWidth-1:0] flit_in_data_i,
  output logic [NumChannels-1:0]               flit_out_valid_o,
  input  logic [NumChannels-1:0]               flit_out_ready_i,
  output logic [NumChannels*FlitDataWidth-1:0] flit_out_data_o,
  output logic                                 axis_out_tvalid_o,
  input  logic                                 axis_out_tready_i,
  output logic [AxisDataWidth-1:0]             axis_out_tdata_o,
  input  logic                                 axis_in_tvalid_i,
  output logic                                 axis_in_tready_o,
  input  logic [AxisDataWidth-1:0]             axis_in_tdata_i,
  output logic [15:0]                          drop_cnt_o,
  output logic                                 drop_pulse_o
);
  localparam int PtrW = RxFifoDepth > 1 ? $clog2(RxFifoDepth) : 1;
  localparam int CntW = $clog2(RxFifoDepth + 1);
  typedef logic [ChanIdxWidth-1:0] idx_t;
  logic tx_valid;
  logic [AxisDataWidth-1:0] tx_data;
  idx_t rr_ptr;
  idx_t gnt;
  logic gnt_found;
  logic tx_can;
  logic tx_acc;
  always_comb begin
    gnt = '0;
    gnt_found = 1'b0;
    for (int i = 0; i < NumChannels; i++) begin
      if (!gnt_found && flit_in_valid_i[(int'(rr_ptr) + i) % NumChannels]) begin
        gnt = idx_t'((int'(rr_ptr) + i) % NumChannels);
        gnt_found = 1'b1;
      end
    end
  end
  assign tx_can = !tx_valid || axis_out_tready_i;
  assign tx_acc = !rst_i && tx_can && gnt_found;
  assign flit_in_ready_o = tx_acc ? NumChannels'(1) << gnt : '0;
  assign axis_out_tvalid_o = tx_valid && !rst_i;
  assign axis_out_tdata_o = tx_data;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tx_valid <= 1'b0;
      tx_data <= '0;
      rr_ptr <= '0;
    end else if (tx_can) begin
      tx_valid <= gnt_found;
      if (gnt_found) begin
        tx_data <= {gnt, flit_in_data_i[gnt*FlitDataWidth +: FlitDataWidth]};
        rr_ptr <= gnt == idx_t'(NumChannels - 1) ? '0 : gnt + 1'b1;
      end
    end
  end
  idx_t rx_idx;
  logic rx_idx_ok;
  logic rx_drop;
  logic drop_q;
  logic [NumChannels-1:0] fifo_full;
  logic [NumChannels-1:0] rx_push;
  logic [NumChannels-1:0] fifo_pop;
  assign rx_idx = axis_in_tdata_i[AxisDataWidth-1 -: ChanIdxWidth];
  assign rx_idx_ok = {1'b0, rx_idx} < (ChanIdxWidth + 1)'(NumChannels);
  // Only the addressed FIFO can stall the link; beats to nonexistent channels are always swallowed.
  assign axis_in_tready_o = !rst_i && (rx_idx_ok ? !fifo_full[rx_idx] : 1'b1);
  assign rx_drop = axis_in_tvalid_i && axis_in_tready_o && !rx_idx_ok;
  for (genvar c = 0; c < NumChannels; c++) begin : g_fifo
    logic [FlitDataWidth-1:0] mem [RxFifoDepth];
    logic [PtrW-1:0] wr_ptr;
    logic [PtrW-1:0] rd_ptr;
    logic [CntW-1:0] cnt;
    assign fifo_full[c] = cnt == CntW'(RxFifoDepth);
    assign rx_push[c] = axis_in_tvalid_i && axis_in_tready_o && rx_idx_ok && rx_idx == idx_t'(c);
    assign flit_out_valid_o[c] = !rst_i && cnt != '0;
    assign fifo_pop[c] = flit_out_valid_o[c] && flit_out_ready_i[c];
    assign flit_out_data_o[c*FlitDataWidth +: FlitDataWidth] = mem[rd_ptr];
    always_ff @(posedge clk_i) begin
      if (rx_push[c]) mem[wr_ptr] <= axis_in_tdata_i[FlitDataWidth-1:0];
    end
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        cnt <= '0;
      end else begin
        if (rx_push[c]) wr_ptr <= wr_ptr == PtrW'(RxFifoDepth - 1) ? '0 : wr_ptr + 1'b1;
        if (fifo_pop[c]) rd_ptr <= rd_ptr == PtrW'(RxFifoDepth - 1) ? '0 : rd_ptr + 1'b1;
        cnt <= cnt + CntW'(rx_push[c]) - CntW'(fifo_pop[c]);
      end
    end
  end
  always_ff @(posedge clk_i) begin
    drop_q <= !rst_i && rx_drop;
  end
  assign drop_pulse_o = drop_q && !rst_i;
`ifdef FLOO_AXIS_BRIDGE_DROP_CNT_EN
  logic [15:0] drop_cnt;
  always_ff @(posedge clk_i) begin
    if (rst_i) drop_cnt <= '0;
    else if (rx_drop && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
  end
  assign drop_cnt_o = drop_cnt;
`else
  assign drop_cnt_o = '0;
`endif
endmodule

// File: tb/tb_floo_axis_noc_bridge_multichannel.sv
// tb_floo_axis_noc_bridge_multichannel: directed scenarios plus random traffic against a queue-based reference model.
module tb_floo_axis_noc_bridge_multichannel;
`ifdef FLOO_AXIS_BRIDGE_DROP_CNT_EN
  localparam int DcEn = 1;
`else
  localparam int DcEn = 0;
`endif
  logic clk = 0;
  logic rst = 1;
  logic [2:0] fin_v, fin_r, fout_v, fout_r;
  logic [47:0] fin_d, fout_d;
  logic tv, tr, iv, ir, dp;
  logic [17:0] td, id;
  logic [15:0] dcnt;
  int checks = 0;
  int errors = 0;
  floo_axis_noc_bridge_multichannel #(.NumChannels(3), .FlitDataWidth(16), .RxFifoDepth(2)) dut (
    .clk_i(clk), .rst_i(rst),
    .flit_in_valid_i(fin_v), .flit_in_ready_o(fin_r), .flit_in_data_i(fin_d),
    .flit_out_valid_o(fout_v), .flit_out_ready_i(fout_r), .flit_out_data_o(fout_d),
    .axis_out_tvalid_o(tv), .axis_out_tready_i(tr), .axis_out_tdata_o(td),
    .axis_in_tvalid_i(iv), .axis_in_tready_o(ir), .axis_in_tdata_i(id),
    .drop_cnt_o(dcnt), .drop_pulse_o(dp)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  // Reference model: one-beat output slot, round-robin pointer, per-channel queues.
  bit m_tv = 0;
  logic [17:0] m_td = '0;
  int m_rr = 0;
  logic [15:0] q [3][$];
  bit m_dp = 0;
  int m_dc = 0;
  function automatic int grant();
    for (int i = 0; i < 3; i++) if (fin_v[(m_rr + i) % 3]) return (m_rr + i) % 3;
    return -1;
  endfunction
  function automatic bit in_ok();
    int ix;
    ix = int'(id[17:16]);
    if (rst) return 0;
    return ix < 3 ? q[ix].size() < 2 : 1'b1;
  endfunction
  always @(posedge clk) begin : model
    int g, ix;
    bit push;
    if (rst) begin
      m_tv = 0;
      m_rr = 0;
      m_dp = 0;
      m_dc = 0;
      for (int c = 0; c < 3; c++) q[c].delete();
    end else begin
      g = grant();
      ix = int'(id[17:16]);
      push = iv && ix < 3 && q[ix].size() < 2;
      m_dp = iv && ix == 3;
      if (m_dp && DcEn == 1 && m_dc < 65535) m_dc++;
      if (!m_tv || tr) begin
        m_tv = g >= 0;
        if (g >= 0) begin
          m_td = {2'(g), fin_d[g*16 +: 16]};
          m_rr = (g + 1) % 3;
        end
      end
      for (int c = 0; c < 3; c++) if (q[c].size() > 0 && fout_r[c]) void'(q[c].pop_front());
      if (push) q[ix].push_back(id[15:0]);
    end
  end
  always @(negedge clk) begin : compare
    int g;
    logic [2:0] er;
    g = grant();
    er = (!rst && (!m_tv || tr) && g >= 0) ? 3'(1 << g) : 3'b000;
    chk("tvalid", 32'(tv), 32'(!rst && m_tv));
    if (!rst && m_tv) chk("tdata", 32'(td), 32'(m_td));
    chk("flit_in_ready", 32'(fin_r), 32'(er));
    chk("axis_in_tready", 32'(ir), 32'(in_ok()));
    for (int c = 0; c < 3; c++) begin
      chk("flit_out_valid", 32'(fout_v[c]), 32'(!rst && q[c].size() > 0));
      if (!rst && q[c].size() > 0) chk("flit_out_data", 32'(fout_d[c*16 +: 16]), 32'(q[c][0]));
    end
    chk("drop_pulse", 32'(dp), 32'(!rst && m_dp));
    chk("drop_cnt", 32'(dcnt), 32'(m_dc));
  end
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  initial begin
    fin_v = 3'b111;
    fin_d = '0;
    fout_r = 3'b111;
    tr = 1;
    iv = 1;
    id = '0;
    @(negedge clk);
    chk("rst tvalid", 32'(tv), 0);
    chk("rst flit_in_ready", 32'(fin_r), 0);
    chk("rst axis_in_tready", 32'(ir), 0);
    chk("rst flit_out_valid", 32'(fout_v), 0);
    chk("rst drop", 32'({dp, dcnt}), 0);
    cyc();
    rst = 0;
    fin_d = {16'h0C02, 16'h0B01, 16'h0A00};
    iv = 0;
    id = {2'd1, 16'h0};
    @(negedge clk);
    chk("tie ch0", 32'(fin_r), 32'b001);
    chk("tready after reset", 32'(ir), 1);
    for (int i = 0; i < 6; i++) begin
      cyc();
      @(negedge clk);
      chk("rr tvalid", 32'(tv), 1);
      chk("rr sequence", 32'(td), 32'({2'(i % 3), 16'h0A00 + 16'(i % 3) * 16'h0101}));
    end
    cyc();
    fin_v = 0;
    cyc();
    fin_v = 3'b010;
    fin_d[31:16] = 16'h00AB;
    tr = 0;
    cyc();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("stall tvalid", 32'(tv), 1);
      chk("stall tdata", 32'(td), 32'h100AB);
      chk("stall flit_in_ready", 32'(fin_r), 0);
      cyc();
    end
    tr = 1;
    fin_v = 0;
    cyc();
    fout_r = 3'b110;
    iv = 1;
    id = {2'd0, 16'h1111};
    cyc();
    id = {2'd0, 16'h2222};
    cyc();
    @(negedge clk);
    chk("ch0 full blocks", 32'(ir), 0);
    chk("ch0 head", 32'({fout_v[0], fout_d[15:0]}), 32'h11111);
    #1;
    id = {2'd1, 16'h3333};
    #1;
    chk("ch1 not blocked", 32'(ir), 1);
    cyc();
    iv = 0;
    fout_r = 3'b111;
    @(negedge clk);
    chk("ch1 head", 32'({fout_v[1], fout_d[31:16]}), 32'h13333);
    repeat (3) cyc();
    iv = 1;
    id = {2'd3, 16'h5555};
    @(negedge clk);
    chk("drop ready", 32'(ir), 1);
    cyc();
    iv = 0;
    @(negedge clk);
    chk("drop pulse", 32'(dp), 1);
    chk("drop no output", 32'(fout_v), 0);
    chk("drop count", 32'(dcnt), 32'(DcEn));
    cyc();
    @(negedge clk);
    chk("drop pulse one cycle", 32'(dp), 0);
    fin_v = 3'b010;
    fin_d[31:16] = 16'hC0DE;
    tr = 0;
    iv = 1;
    id = {2'd1, 16'h7777};
    fout_r = 3'b000;
    cyc();
    iv = 0;
    fin_v = 0;
    @(negedge clk);
    chk("pre-reset tdata", 32'(td), 32'h1C0DE);
    chk("pre-reset fifo", 32'(fout_v), 32'b010);
    #1;
    rst = 1;
    #1;
    chk("reset tvalid", 32'(tv), 0);
    chk("reset flit_out_valid", 32'(fout_v), 0);
    cyc();
    rst = 0;
    tr = 1;
    fout_r = 3'b111;
    @(negedge clk);
    chk("no stale tvalid", 32'(tv), 0);
    chk("no stale flit_out", 32'(fout_v), 0);
    #1;
    fin_v = 3'b111;
    #1;
    chk("rr reset", 32'(fin_r), 32'b001);
    cyc();
    for (int n = 0; n < 4000; n++) begin
      rst = $urandom_range(0, 199) == 0;
      fin_v = 3'($urandom);
      fin_d = {16'($urandom), 16'($urandom), 16'($urandom)};
      fout_r = 3'($urandom);
      tr = $urandom_range(0, 3) != 0;
      iv = 1'($urandom);
      id = 18'($urandom);
      cyc();
    end
    rst = 0;
    fin_v = 0;
    iv = 0;
    tr = 1;
    fout_r = 3'b111;
    repeat (5) cyc();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/floo_axis_noc_bridge_multichannel.md
FLOO_AXIS_NOC_BRIDGE_MULTICHANNEL -- requirements
Module: floo_axis_noc_bridge_multichannel

Interface
REQ-001 SHALL have parameter NumChannels, default 2, number of NoC flit channels multiplexed onto one AXIS link (legal range 2..16).
REQ-002 SHALL have parameter FlitDataWidth, default 64, payload bits per flit.
REQ-003 SHALL have parameter RxFifoDepth, default 2, entries per per-channel receive FIFO (legal range >=1).
REQ-004 SHALL define derived ChanIdxWidth = max(1, clog2(NumChannels)) and AxisDataWidth = ChanIdxWidth + FlitDataWidth; AXIS tdata = {channel index (MSBs), flit data (LSBs)}.
REQ-005 SHALL have ports (clock and reset first):
 clk_i  in  1  single clock; all state on rising edge
 rst_i  in  1  reset, synchronous, active-high
 flit_in_valid_i  in  NumChannels  per-channel flit valid, NoC side toward link
 flit_in_ready_o  out  NumChannels  per-channel flit ready
 flit_in_data_i  in  NumChannels*FlitDataWidth  channel c at bits [c*W +: W]
 flit_out_valid_o  out  NumChannels  per-channel flit valid, link toward NoC
 flit_out_ready_i  in  NumChannels  per-channel flit ready
 flit_out_data_o  out  NumChannels*FlitDataWidth  same packing
 axis_out_tvalid_o  out  1  outgoing AXIS valid
 axis_out_tready_i  in  1  outgoing AXIS ready
 axis_out_tdata_o  out  AxisDataWidth  outgoing beat
 axis_in_tvalid_i  in  1  incoming AXIS valid
 axis_in_tready_o  out  1  incoming AXIS ready
 axis_in_tdata_i  in  AxisDataWidth  incoming beat
 drop_cnt_o  out  16  count of discarded incoming beats
 drop_pulse_o  out  1  one-cycle strobe per discarded beat

Function
REQ-006 TX SHALL use a one-entry output register; tvalid/tdata driven only from it (1-cycle latency flit accept -> tvalid).
REQ-007 Register SHALL accept a new flit when empty or when drained in the same cycle (tvalid & tready); full throughput of one beat per cycle.
REQ-008 TX arbitration SHALL be round-robin: grant = first c with flit_in_valid_i[c], searching from rr_ptr upward with wrap from NumChannels-1 to 0.
REQ-009 flit_in_ready_o SHALL be one-hot or zero: high only for granted channel when register can accept; all others low.
REQ-010 On accepted flit from channel g, rr_ptr SHALL update to (g+1) mod NumChannels; no update without acceptance.
REQ-011 axis_out_tdata_o and tvalid SHALL hold stable while tvalid & !tready.
REQ-012 RX SHALL decode idx = tdata MSBs; idx < NumChannels -> axis_in_tready_o = not-full of FIFO idx only (no head-of-line blocking on other channels).
REQ-013 RX beat with idx >= NumChannels SHALL be accepted (tready=1) and discarded; drop_pulse_o high the following cycle.
REQ-014 RX FIFOs SHALL be non-fall-through: beat written cycle t visible on flit_out_valid_o earliest cycle t+1; FIFO full at RxFifoDepth entries; simultaneous push and pop on a full FIFO SHALL NOT be allowed (push gated by not-full only).
REQ-015 flit_out_valid_o[c] SHALL be high iff FIFO c non-empty; pop on valid & ready; per-channel data order preserved.

Reset
REQ-016 While rst_i high: axis_out_tvalid_o=0, flit_out_valid_o=0, flit_in_ready_o=0, axis_in_tready_o=0, drop_pulse_o=0.
REQ-017 Reset SHALL set rr_ptr=0, empty output register and all FIFOs, drop_cnt_o=0; reset mid-transfer discards in-flight beats with no partial output after release.
REQ-018 First cycle after rst_i low: axis_in_tready_o=1 for any valid idx; channel 0 wins ties.

Configuration
REQ-019 Macro FLOO_AXIS_BRIDGE_DROP_CNT_EN defined: drop_cnt_o increments by 1 per discarded beat, saturates at 16'hFFFF.
REQ-020 Macro undefined: counter not instantiated, drop_cnt_o tied 0; drop_pulse_o unaffected.

Verification
REQ-021 N=3, channels 0,1,2 all valid continuously, tready=1 -> tdata idx sequence 0,1,2,0,1,2, one beat per cycle after 1-cycle latency.
REQ-022 Channel 1 valid data 0xAB, tready=0 for 5 cycles -> tvalid high, tdata {1,0xAB} stable all 5 cycles; flit_in_ready_o=0 throughout.
REQ-023 RxFifoDepth=2, 2 beats to ch0 with flit_out_ready_i[0]=0 -> ch0 full, tready=0 for idx 0, beat to idx 1 accepted same cycle.
REQ-024 N=3, incoming beat idx=3 -> tready=1, no flit_out_valid_o, drop_pulse_o 1 cycle, drop_cnt_o 0->1 (macro defined) or stays 0 (undefined).
REQ-025 rst_i asserted with TX register full and FIFO 1 holding 1 entry -> next cycle all valids 0, rr_ptr=0, no stale beat after release.
